// File: rtl/fx_block_accum_requant_if.sv
// Sample-in / block-result-out bundle for the block accumulate-and-requantize stage.
// The master drives samples and clear; the slave returns the requantized block result.
interface fx_block_accum_requant_if #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12
);
  logic                    i_valid;
  logic signed [IN_W-1:0]  i_data;
  logic                    i_clear;
  logic                    o_valid;
  logic signed [OUT_W-1:0] o_data;
  logic                    o_ovf;

  modport master (
    output i_valid, i_data, i_clear,
    input  o_valid, o_data, o_ovf
  );

  modport slave (
    input  i_valid, i_data, i_clear,
    output o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/fx_block_accum_requant.sv
// Integrates fixed blocks of ACC_LEN signed samples, then rounds, shifts and saturates or wraps
// each block sum to OUT_W bits. Emits one single-cycle result strobe per completed block.
module fx_block_accum_requant #(
  parameter int IN_W     = 13,
  parameter int ACC_LEN  = 8,
  parameter int ACC_W    = IN_W + $clog2(ACC_LEN),
  parameter int SHIFT    = 3,
  parameter int OUT_W    = 12,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input logic                     clk,
  input logic                     rst,
  fx_block_accum_requant_if.slave bus
);

  localparam int CNT_W = $clog2(ACC_LEN);

  localparam logic signed [ACC_W:0] RND   = (ROUND_EN != 0) ? ((ACC_W+1)'(1) <<< (SHIFT-1)) : '0;
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

  // Returns {ovf, data}; on overflow the code either clamps or keeps the low OUT_W bits.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] q);
    logic [OUT_W:0] res;
    if (q > Q_MAX) begin
      res = {1'b1, (SAT_EN != 0) ? Q_MAX[OUT_W-1:0] : q[OUT_W-1:0]};
    end else if (q < Q_MIN) begin
      res = {1'b1, (SAT_EN != 0) ? Q_MIN[OUT_W-1:0] : q[OUT_W-1:0]};
    end else begin
      res = {1'b0, q[OUT_W-1:0]};
    end
    return res;
  endfunction

  // One extra bit of headroom so the rounding offset can never wrap the sum.
  function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] q;
    r = $signed({sum[ACC_W-1], sum}) + RND;
    q = r >>> SHIFT;
    return saturate(q);
  endfunction

  logic signed [ACC_W-1:0] acc_p0;
  logic        [CNT_W-1:0] cnt_p0;
  logic signed [ACC_W-1:0] sum_p0;
  logic                    last_p0;
  logic signed [ACC_W-1:0] sum_p1;
  logic                    vld_p1;
  logic        [OUT_W:0]   res_p1;

  assign sum_p0  = acc_p0 + $signed({{(ACC_W-IN_W){bus.i_data[IN_W-1]}}, bus.i_data});
  assign last_p0 = (cnt_p0 == CNT_W'(ACC_LEN - 1));
  assign res_p1  = requant(sum_p1);

  // Stage p0 -> p1: accumulate; the completed block sum is handed to the requantizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0      <= '0;
      cnt_p0      <= '0;
      vld_p1      <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_ovf   <= 1'b0;
    end else begin
      vld_p1      <= 1'b0;
      bus.o_valid <= vld_p1;
      if (vld_p1) begin
        {bus.o_ovf, bus.o_data} <= res_p1;
      end
      if (bus.i_clear) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (bus.i_valid) begin
        if (last_p0) begin
          acc_p0 <= '0;
          cnt_p0 <= '0;
          vld_p1 <= 1'b1;
        end else begin
          acc_p0 <= sum_p0;
          cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
      end
    end
  end

  // Stage p1 data: captured only when a block completes; qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (bus.i_valid && !bus.i_clear && last_p0) begin
      sum_p1 <= sum_p0;
    end
  end

endmodule

// File: tb/tb_fx_block_accum_requant.sv
// Drives one stimulus stream into three configurations (round+sat, truncate+sat, round+wrap)
// and checks every output each cycle against a queue-based block model.
module tb_fx_block_accum_requant;

  localparam int IN_W    = 13;
  localparam int OUT_W   = 12;
  localparam int ACC_LEN = 8;
  localparam int SHIFT   = 3;
  localparam int NCFG    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_valid = 1'b0;
  logic drv_clear = 1'b0;
  logic signed [IN_W-1:0] drv_data = '0;

  always #5 clk = ~clk;

  fx_block_accum_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus0 ();
  fx_block_accum_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();
  fx_block_accum_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus2 ();

  assign bus0.i_valid = drv_valid;
  assign bus0.i_data  = drv_data;
  assign bus0.i_clear = drv_clear;
  assign bus1.i_valid = drv_valid;
  assign bus1.i_data  = drv_data;
  assign bus1.i_clear = drv_clear;
  assign bus2.i_valid = drv_valid;
  assign bus2.i_data  = drv_data;
  assign bus2.i_clear = drv_clear;

  fx_block_accum_requant dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fx_block_accum_requant #(.ROUND_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fx_block_accum_requant #(.SAT_EN(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic                    obs_v [NCFG];
  logic signed [OUT_W-1:0] obs_d [NCFG];
  logic                    obs_o [NCFG];

  assign obs_v[0] = bus0.o_valid;
  assign obs_d[0] = bus0.o_data;
  assign obs_o[0] = bus0.o_ovf;
  assign obs_v[1] = bus1.o_valid;
  assign obs_d[1] = bus1.o_data;
  assign obs_o[1] = bus1.o_ovf;
  assign obs_v[2] = bus2.o_valid;
  assign obs_d[2] = bus2.o_data;
  assign obs_o[2] = bus2.o_ovf;

  bit cfg_rnd [NCFG] = '{1'b1, 1'b0, 1'b1};
  bit cfg_sat [NCFG] = '{1'b1, 1'b1, 1'b0};

  int errors = 0;
  int checks = 0;

  // Reference state: accepted samples of the open block, a result awaiting output, visible outputs.
  int samples[$];
  bit pend_v   = 1'b0;
  int pend_sum = 0;
  int exp_v [NCFG];
  int exp_d [NCFG];
  int exp_o [NCFG];

  function automatic void ref_requant(input int sum, input bit rnd, input bit sat,
                                      output int d, output int ovf);
    int r;
    int q;
    int lim;
    lim = 1 << (OUT_W - 1);
    r = sum + (rnd ? (1 << (SHIFT - 1)) : 0);
    q = r >>> SHIFT;
    ovf = (q > lim - 1 || q < -lim) ? 1 : 0;
    if (ovf == 1 && sat) d = (q > 0) ? lim - 1 : -lim;
    else d = ((q + lim) % (2 * lim) + 2 * lim) % (2 * lim) - lim;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input bit v, input int d, input bit c, input bit r);
    int s;
    drv_valid = v;
    drv_data  = IN_W'(d);
    drv_clear = c;
    rst       = r;
    @(posedge clk);
    if (r) begin
      samples.delete();
      pend_v = 1'b0;
      for (int k = 0; k < NCFG; k++) begin
        exp_v[k] = 0;
        exp_d[k] = 0;
        exp_o[k] = 0;
      end
    end else begin
      for (int k = 0; k < NCFG; k++) begin
        exp_v[k] = pend_v ? 1 : 0;
        if (pend_v) ref_requant(pend_sum, cfg_rnd[k], cfg_sat[k], exp_d[k], exp_o[k]);
      end
      pend_v = 1'b0;
      if (c) begin
        samples.delete();
      end else if (v) begin
        samples.push_back(d);
        if (samples.size() == ACC_LEN) begin
          s = 0;
          foreach (samples[i]) s += samples[i];
          pend_sum = s;
          pend_v   = 1'b1;
          samples.delete();
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("cfg%0d_o_valid", k), {31'b0, obs_v[k]}, exp_v[k]);
      chk($sformatf("cfg%0d_o_data", k), obs_d[k], exp_d[k]);
      chk($sformatf("cfg%0d_o_ovf", k), {31'b0, obs_o[k]}, exp_o[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(8191)) - 4096, 1'b0, 1'b0);
  endtask

  task automatic block(input int val, input int n);
    for (int i = 0; i < n; i++) step(1'b1, val, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(2);

    block(100, 8);
    idle(3);

    step(1'b1, 4, 1'b0, 1'b0);
    block(0, 7);
    idle(2);
    step(1'b1, -4, 1'b0, 1'b0);
    block(0, 7);
    idle(2);

    block(4095, 8);
    idle(2);
    block(-4096, 8);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16, 1'b0, 1'b0);
      idle(int'($urandom_range(5, 1)));
    end
    idle(2);
    block(16, 16);
    idle(3);

    block(1000, 5);
    step(1'b0, 0, 1'b1, 1'b0);
    block(8, 8);
    idle(2);

    block(1, 7);
    step(1'b1, 1, 1'b1, 1'b0);
    idle(3);

    block(50, 8);
    step(1'b1, 7, 1'b1, 1'b0);
    idle(2);

    block(300, 3);
    step(1'b0, 0, 1'b0, 1'b1);
    block(200, 8);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(3) != 0, int'($urandom_range(8191)) - 4096,
           $urandom_range(40) == 0, 1'b0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
